// File: rtl/cc_pkg.sv
// Shared types and constants for the cache hit/miss dispatch path.
// Burst constants describe one 64-byte line fetched as eight 8-byte beats, critical word first.
package cc_pkg;

  localparam int CC_LINE_W   = 512;
  localparam int CC_OFFSET_W = 6;
  localparam int CC_BEATS    = 8;

  localparam logic [3:0] CC_ARLEN        = 4'(CC_BEATS - 1);
  localparam logic [2:0] CC_ARSIZE       = 3'b011;
  localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

  typedef struct packed {
    logic [CC_OFFSET_W-1:0] offset;
    logic [CC_LINE_W-1:0]   line;
  } cc_hit_entry_t;

  typedef enum logic {
    IDLE,
    AR_WAIT
  } cc_state_e;

endpackage

// File: rtl/cc_miss_credit_counter.sv
// Counts misses issued on AR whose R burst has not yet finished.
// A return with no outstanding miss is dropped so the count never underflows.
module cc_miss_credit_counter #(
  parameter int MAX_OUTSTANDING_MISS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       full_o
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING_MISS);

  logic [3:0] r_count;
  logic       w_dec_ok;

  assign w_dec_ok = dec_i && (r_count != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (inc_i && !w_dec_ok) begin
      r_count <= r_count + 4'd1;
    end else if (!inc_i && w_dec_ok) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign count_o = r_count;
  assign full_o  = (r_count >= MAX_C);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec_i && r_count == 4'd0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc_i && full_o && !dec_i));

endmodule

// File: rtl/cc_hit_miss_dispatcher.sv
// Routes tag-compare results: hits go to the hit data FIFO, misses become one WRAP read on AR.
// Every accepted lookup leaves an ordered hit/miss flag for the reorder unit.
module cc_hit_miss_dispatcher
  import cc_pkg::*;
#(
  parameter int MAX_OUTSTANDING_MISS = 4,
  parameter int ADDR_WIDTH           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid_i,
  input  logic                  lookup_hit_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  input  logic [CC_LINE_W-1:0]  lookup_data_i,
  output logic                  lookup_ready_o,
  input  logic                  hit_flag_fifo_afull_i,
  output logic                  hit_flag_fifo_wren_o,
  output logic                  hit_flag_fifo_wdata_o,
  input  logic                  hit_data_fifo_afull_i,
  output logic                  hit_data_fifo_wren_o,
  output logic [517:0]          hit_data_fifo_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rready_i,
  input  logic                  mem_rlast_i
);

  cc_state_e             r_state;
  cc_state_e             w_state_next;
  logic                  r_flag_wren;
  logic                  r_flag_wdata;
  logic                  r_data_wren;
  cc_hit_entry_t         r_data_wdata;
  logic [ADDR_WIDTH-1:0] r_araddr;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_hit_accept;
  logic                  w_miss_accept;
  logic                  w_rlast_beat;
  logic                  w_credit_full;
  logic [3:0]            w_credit_count;

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = !hit_flag_fifo_afull_i &&
                  (lookup_hit_i ? !hit_data_fifo_afull_i : !w_credit_full);
        if (lookup_valid_i && w_ready && !lookup_hit_i) begin
          w_state_next = AR_WAIT;
        end
      end
      AR_WAIT: begin
        if (mem_arready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign lookup_ready_o = rst_n && w_ready;
  assign w_accept       = lookup_valid_i && lookup_ready_o;
  assign w_hit_accept   = w_accept && lookup_hit_i;
  assign w_miss_accept  = w_accept && !lookup_hit_i;
  assign w_rlast_beat   = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  // Flag is written at accept, not at the AR handshake, so flag order always matches lookup order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_flag_wren  <= 1'b0;
      r_flag_wdata <= 1'b0;
      r_data_wren  <= 1'b0;
      r_data_wdata <= '0;
      r_araddr     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flag_wren <= w_accept;
      r_data_wren <= w_hit_accept;
      if (w_accept) begin
        r_flag_wdata <= lookup_hit_i;
      end
      if (w_hit_accept) begin
        r_data_wdata.offset <= lookup_addr_i[CC_OFFSET_W-1:0];
        r_data_wdata.line   <= lookup_data_i;
      end
      if (w_miss_accept) begin
        r_araddr <= {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
      end
    end
  end

  cc_miss_credit_counter #(
    .MAX_OUTSTANDING_MISS(MAX_OUTSTANDING_MISS)
  ) u_credit (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (w_miss_accept),
    .dec_i  (w_rlast_beat),
    .count_o(w_credit_count),
    .full_o (w_credit_full)
  );

  assign hit_flag_fifo_wren_o  = r_flag_wren;
  assign hit_flag_fifo_wdata_o = r_flag_wdata;
  assign hit_data_fifo_wren_o  = r_data_wren;
  assign hit_data_fifo_wdata_o = r_data_wdata;
  assign mem_araddr_o          = r_araddr;
  assign mem_arvalid_o         = (r_state == AR_WAIT);
  assign mem_arlen_o           = CC_ARLEN;
  assign mem_arsize_o          = CC_ARSIZE;
  assign mem_arburst_o         = CC_ARBURST_WRAP;

endmodule

// File: tb/tb_cc_hit_miss_dispatcher.sv
// Directed bench for cc_hit_miss_dispatcher: inputs change 1 ns after posedge, outputs sampled there.
// Credit count is observed through the top-level w_credit_count net.
module tb_cc_hit_miss_dispatcher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lookup_valid, lookup_hit, lookup_ready;
  logic [31:0]  lookup_addr;
  logic [511:0] lookup_data;
  logic         flag_afull, flag_wren, flag_wdata;
  logic         data_afull, data_wren;
  logic [517:0] data_wdata;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready, rvalid, rready, rlast;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_hit_miss_dispatcher #(.MAX_OUTSTANDING_MISS(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid), .lookup_hit_i(lookup_hit),
    .lookup_addr_i(lookup_addr), .lookup_data_i(lookup_data),
    .lookup_ready_o(lookup_ready),
    .hit_flag_fifo_afull_i(flag_afull), .hit_flag_fifo_wren_o(flag_wren),
    .hit_flag_fifo_wdata_o(flag_wdata),
    .hit_data_fifo_afull_i(data_afull), .hit_data_fifo_wren_o(data_wren),
    .hit_data_fifo_wdata_o(data_wdata),
    .mem_araddr_o(araddr), .mem_arlen_o(arlen), .mem_arsize_o(arsize),
    .mem_arburst_o(arburst), .mem_arvalid_o(arvalid), .mem_arready_i(arready),
    .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rlast_beats(input int n);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    repeat (n) tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_2031;
    #1;
    checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", lookup_ready); end
    tick();
    checks++; if (arvalid !== 1'b0 || flag_wren !== 1'b0 || data_wren !== 1'b0) begin
      failures++; $display("FAIL reset_strobes got arvalid=%b flag_wren=%b data_wren=%b exp=0", arvalid, flag_wren, data_wren); end
    checks++; if (araddr !== 32'h0 || data_wdata !== 518'h0) begin
      failures++; $display("FAIL reset_data got araddr=%h exp=0", araddr); end
    checks++; if (dut.w_credit_count !== 4'd0) begin failures++; $display("FAIL reset_credits got=%0d exp=0", dut.w_credit_count); end
    lookup_valid = 1'b0; rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single_hit();
    logic [511:0] pat;
    for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h0000_1028; lookup_data = pat;
    #1;
    checks++; if (lookup_ready !== 1'b1) begin failures++; $display("FAIL hit_ready got=%b exp=1", lookup_ready); end
    tick();
    lookup_valid = 1'b0;
    checks++; if (flag_wren !== 1'b1 || flag_wdata !== 1'b1) begin
      failures++; $display("FAIL hit_flag got wren=%b wdata=%b exp 1/1", flag_wren, flag_wdata); end
    checks++; if (data_wren !== 1'b1 || data_wdata[517:512] !== 6'h28) begin
      failures++; $display("FAIL hit_offset got wren=%b off=%h exp 1/28", data_wren, data_wdata[517:512]); end
    checks++; if (data_wdata[511:0] !== pat) begin failures++; $display("FAIL hit_line got=%h exp=%h", data_wdata[511:0], pat); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL hit_arvalid got=%b exp=0", arvalid); end
    tick();
    checks++; if (flag_wren !== 1'b0 || data_wren !== 1'b0) begin
      failures++; $display("FAIL hit_pulse got flag=%b data=%b exp 0/0", flag_wren, data_wren); end
    $display("hit addr=%h offset=28", 32'h0000_1028);
  endtask

  task automatic test_single_miss();
    arready = 1'b0;
    lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_2031;
    #1;
    checks++; if (lookup_ready !== 1'b1) begin failures++; $display("FAIL miss_ready got=%b exp=1", lookup_ready); end
    tick();
    lookup_valid = 1'b0; lookup_hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) arready = 1'b1;
      #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_2030) begin
        failures++; $display("FAIL miss_ar cyc=%0d got arvalid=%b araddr=%h exp 1/00002030", i, arvalid, araddr); end
      checks++; if (arlen !== 4'd7 || arsize !== 3'b011 || arburst !== 2'b10) begin
        failures++; $display("FAIL miss_arconst got len=%0d size=%0d burst=%0d exp 7/3/2", arlen, arsize, arburst); end
      checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL miss_ready_wait cyc=%0d got=%b exp=0", i, lookup_ready); end
      checks++; if (flag_wren !== (i == 0) || (i == 0 && flag_wdata !== 1'b0)) begin
        failures++; $display("FAIL miss_flag cyc=%0d got wren=%b wdata=%b", i, flag_wren, flag_wdata); end
      checks++; if (dut.w_credit_count !== 4'd1) begin failures++; $display("FAIL miss_credits got=%0d exp=1", dut.w_credit_count); end
      tick();
    end
    arready = 1'b0;
    #1;
    checks++; if (arvalid !== 1'b0 || lookup_ready !== 1'b1) begin
      failures++; $display("FAIL miss_done got arvalid=%b ready=%b exp 0/1", arvalid, lookup_ready); end
    rlast_beats(1);
    checks++; if (dut.w_credit_count !== 4'd0) begin failures++; $display("FAIL miss_drain got=%0d exp=0", dut.w_credit_count); end
    $display("miss addr=%h araddr=%h", 32'h0000_2031, 32'h0000_2030);
  endtask

  task automatic test_credit_limit();
    int n = 0;
    arready = 1'b1;
    lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_3000;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (flag_wren === 1'b1) n++;
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL limit_accepts got=%0d exp=4", n); end
    checks++; if (dut.w_credit_count !== 4'd4) begin failures++; $display("FAIL limit_credits got=%0d exp=4", dut.w_credit_count); end
    checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL limit_miss_blocked got=%b exp=0", lookup_ready); end
    lookup_hit = 1'b1; lookup_addr = 32'h0000_3004; lookup_data = '0;
    #1;
    checks++; if (lookup_ready !== 1'b1) begin failures++; $display("FAIL limit_hit_ready got=%b exp=1", lookup_ready); end
    tick();
    lookup_valid = 1'b0;
    checks++; if (flag_wren !== 1'b1 || flag_wdata !== 1'b1) begin
      failures++; $display("FAIL limit_hit_flag got wren=%b wdata=%b exp 1/1", flag_wren, flag_wdata); end
    rlast_beats(1);
    checks++; if (dut.w_credit_count !== 4'd3) begin failures++; $display("FAIL limit_return got=%0d exp=3", dut.w_credit_count); end
    lookup_valid = 1'b1; lookup_hit = 1'b0;
    #1;
    checks++; if (lookup_ready !== 1'b1) begin failures++; $display("FAIL limit_reopen got=%b exp=1", lookup_ready); end
    tick();
    lookup_valid = 1'b0;
    checks++; if (dut.w_credit_count !== 4'd4 || flag_wren !== 1'b1) begin
      failures++; $display("FAIL limit_reaccept got credits=%0d wren=%b exp 4/1", dut.w_credit_count, flag_wren); end
    tick();
    rlast_beats(2);
    checks++; if (dut.w_credit_count !== 4'd2) begin failures++; $display("FAIL limit_drain2 got=%0d exp=2", dut.w_credit_count); end
    lookup_valid = 1'b1; lookup_hit = 1'b0; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    #1;
    tick();
    lookup_valid = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++; if (dut.w_credit_count !== 4'd2 || flag_wren !== 1'b1) begin
      failures++; $display("FAIL simul_inc_dec got credits=%0d wren=%b exp 2/1", dut.w_credit_count, flag_wren); end
    tick();
    rlast_beats(2);
    checks++; if (dut.w_credit_count !== 4'd0) begin failures++; $display("FAIL limit_drain0 got=%0d exp=0", dut.w_credit_count); end
    arready = 1'b0;
    $display("credit limit: %0d misses accepted before stall", n);
  endtask

  task automatic test_back_to_back();
    bit          kind  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] addr_t[5] = '{32'h0000_6005, 32'h0000_6100, 32'h0000_6211, 32'h0000_6211, 32'h0000_633F};
    bit          exp_fw[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit          exp_dw[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  order = '0;
    int          nflag = 0;
    int          ndata = 0;
    arready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      lookup_valid = 1'b1; lookup_hit = kind[c]; lookup_addr = addr_t[c];
      lookup_data = {16{32'h5A00_0000 + 32'(c)}};
      tick();
      if (flag_wren === 1'b1) begin order = {order[2:0], flag_wdata}; nflag++; end
      if (data_wren === 1'b1) ndata++;
      checks++; if (flag_wren !== exp_fw[c] || data_wren !== exp_dw[c]) begin
        failures++; $display("FAIL stream_wren cyc=%0d got flag=%b data=%b exp %b/%b", c, flag_wren, data_wren, exp_fw[c], exp_dw[c]); end
      if (exp_dw[c]) begin
        checks++; if (data_wdata[517:512] !== addr_t[c][5:0]) begin
          failures++; $display("FAIL stream_offset cyc=%0d got=%h exp=%h", c, data_wdata[517:512], addr_t[c][5:0]); end
      end
    end
    lookup_valid = 1'b0;
    checks++; if (order !== 4'b1011 || nflag !== 4) begin
      failures++; $display("FAIL stream_order got=%b n=%0d exp=1011 n=4", order, nflag); end
    checks++; if (ndata !== 3) begin failures++; $display("FAIL stream_data_writes got=%0d exp=3", ndata); end
    tick();
    rlast_beats(1);
    arready = 1'b0;
    $display("stream H,M,H,H flags=%b data_writes=%0d", order, ndata);
  endtask

  task automatic test_backpressure();
    arready = 1'b1; data_afull = 1'b1;
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h0000_4000;
    #1;
    checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL bp_data_ready got=%b exp=0", lookup_ready); end
    tick();
    checks++; if (flag_wren !== 1'b0 || data_wren !== 1'b0) begin
      failures++; $display("FAIL bp_data_nowrite got flag=%b data=%b exp 0/0", flag_wren, data_wren); end
    lookup_hit = 1'b0; lookup_addr = 32'h0000_4008;
    #1;
    checks++; if (lookup_ready !== 1'b1) begin failures++; $display("FAIL bp_miss_ready got=%b exp=1", lookup_ready); end
    tick();
    lookup_valid = 1'b0;
    checks++; if (flag_wren !== 1'b1 || flag_wdata !== 1'b0 || data_wren !== 1'b0 || arvalid !== 1'b1) begin
      failures++; $display("FAIL bp_miss got flag=%b/%b data=%b arvalid=%b exp 1/0/0/1", flag_wren, flag_wdata, data_wren, arvalid); end
    tick();
    data_afull = 1'b0;
    rlast_beats(1);
    flag_afull = 1'b1; lookup_valid = 1'b1; lookup_hit = 1'b1;
    #1;
    checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL bp_flag_hit got=%b exp=0", lookup_ready); end
    lookup_hit = 1'b0;
    #1;
    checks++; if (lookup_ready !== 1'b0) begin failures++; $display("FAIL bp_flag_miss got=%b exp=0", lookup_ready); end
    tick();
    checks++; if (flag_wren !== 1'b0 || data_wren !== 1'b0 || arvalid !== 1'b0) begin
      failures++; $display("FAIL bp_flag_nowrite got flag=%b data=%b arvalid=%b exp 0", flag_wren, data_wren, arvalid); end
    lookup_valid = 1'b0; flag_afull = 1'b0; arready = 1'b0;
    tick();
    $display("backpressure: data afull stalls hit, flag afull stalls all");
  endtask

  task automatic test_reset_ar_wait();
    arready = 1'b0;
    lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_5040;
    #1;
    tick();
    lookup_valid = 1'b0;
    checks++; if (arvalid !== 1'b1 || dut.w_credit_count !== 4'd1) begin
      failures++; $display("FAIL rst_wait_pre got arvalid=%b credits=%0d exp 1/1", arvalid, dut.w_credit_count); end
    rst_n = 1'b0;
    tick();
    checks++; if (arvalid !== 1'b0 || dut.w_credit_count !== 4'd0 || lookup_ready !== 1'b0) begin
      failures++; $display("FAIL rst_wait_post got arvalid=%b credits=%0d ready=%b exp 0/0/0", arvalid, dut.w_credit_count, lookup_ready); end
    rst_n = 1'b1; lookup_hit = 1'b1;
    tick();
    checks++; if (lookup_ready !== 1'b1 || arvalid !== 1'b0) begin
      failures++; $display("FAIL rst_wait_idle got ready=%b arvalid=%b exp 1/0", lookup_ready, arvalid); end
    $display("reset during AR_WAIT dropped arvalid");
  endtask

  initial begin
    rst_n = 1'b0; lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_addr = '0; lookup_data = '0;
    flag_afull = 1'b0; data_afull = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    tick();
    tick();
    test_reset();
    test_single_hit();
    test_single_miss();
    test_credit_limit();
    test_back_to_back();
    test_backpressure();
    test_reset_ar_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
